pagerank_stream_tx: RTL and testbench
=====================================

PAGERANK_STREAM_TX -- requirements
Module: pagerank_stream_tx

Interface
REQ-001 Parameter NUM_HW_THREADS, default 8: number of graph partitions (hardware threads) contributing partial vectors; must be >= 2.
REQ-002 Parameter NODES_IN_GRAPH, default 32: number of 64-bit node entries per partial vector.
REQ-003 clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 wr_valid  input  1  a partial vector is offered on wr_thread_id / wr_vector.
REQ-006 wr_thread_id  input  $clog2(NUM_HW_THREADS)  index of the partition that owns wr_vector.
REQ-007 wr_vector  input  64 x NODES_IN_GRAPH  partial pagerank contributions of one thread.
REQ-008 wr_ready  output  1  block accepts a write this cycle.
REQ-009 stream_hold  input  1  downstream stall; freezes the current beat.
REQ-010 pagerank_serial_stream  output  64 x NODES_IN_GRAPH  current streamed vector.
REQ-011 stream_start  output  1  one-cycle pulse preceding the first beat.
REQ-012 stream_valid  output  1  pagerank_serial_stream holds a valid beat.
REQ-013 stream_done  output  1  one-cycle pulse after the last beat.
REQ-014 thread_loaded  output  NUM_HW_THREADS  per-thread "vector buffered" flags.
REQ-015 dup_write_err  output  1  sticky: a loaded thread was written again.

Function
REQ-016 Buffer SHALL hold NUM_HW_THREADS vectors, one slot per thread id.
REQ-017 FSM states SHALL be COLLECT, START, STREAM, DONE.
REQ-018 wr_ready SHALL be 1 only in COLLECT; a write is accepted when wr_valid && wr_ready at a rising edge.
REQ-019 Accepted write: slot[wr_thread_id] <= wr_vector, thread_loaded[wr_thread_id] <= 1.
REQ-020 Write to an already-loaded slot: overwrite the slot, set dup_write_err; flag stays set until reset.
REQ-021 wr_thread_id >= NUM_HW_THREADS: write ignored, no flag changes, dup_write_err set.
REQ-022 COLLECT -> START on the edge where the accepted write makes all thread_loaded bits 1 (including via a last write).
REQ-023 START: stream_start = 1 for exactly one cycle, stream_valid = 0; START -> STREAM unconditionally.
REQ-024 STREAM: stream_valid = 1, pagerank_serial_stream = slot[beat_idx], beat_idx starting at 0.
REQ-025 In STREAM with stream_hold = 0: beat_idx increments each cycle; with stream_hold = 1: beat_idx and output are held.
REQ-026 STREAM -> DONE on the edge where beat_idx == NUM_HW_THREADS-1 and stream_hold = 0; exactly NUM_HW_THREADS beats are emitted, in thread order 0..N-1.
REQ-027 DONE: stream_done = 1 for one cycle; all thread_loaded cleared, beat_idx = 0; DONE -> COLLECT.
REQ-028 stream_hold SHALL be ignored outside STREAM.
REQ-029 Latency: last write accepted at edge k -> stream_start high in cycle k+1, first beat in k+2, stream_done in k+2+NUM_HW_THREADS (no holds).
REQ-030 pagerank_serial_stream SHALL be all-zero whenever stream_valid = 0.
REQ-031 No arithmetic on data; vectors pass bit-exact.

Reset
REQ-032 Reset SHALL force COLLECT, beat_idx = 0, thread_loaded = 0, dup_write_err = 0, stream_start = stream_valid = stream_done = 0, and all buffer slots to 0.
REQ-033 Reset asserted mid-STREAM SHALL abort the stream with no stream_done pulse; wr_ready = 1 in the cycle after reset deasserts.
REQ-034 A write coincident with reset SHALL be discarded.

Verification
REQ-035 NUM_HW_THREADS=8: write threads 7..0 with vector[i] = 64'h100*t + i -> stream_start one cycle after last write, then 8 beats in thread order 0..7, then stream_done, wr_ready = 1 again.
REQ-036 Hold stream_hold = 1 for 3 cycles during beat 2 -> beat 2 repeated for 4 cycles total, 8 distinct beats, stream_done 3 cycles later than nominal.
REQ-037 Write thread 3 twice (values A then B) before completing set -> dup_write_err = 1, streamed beat 3 = B.
REQ-038 Assert reset during beat 4 -> all outputs 0 next cycle, no stream_done, thread_loaded = 0.
REQ-039 wr_valid asserted during START/STREAM -> wr_ready = 0, write ignored, next iteration's thread_loaded unaffected.
REQ-040 Two back-to-back iterations -> second stream carries only second-iteration data, stream_start count = stream_done count = 2.

Source files
------------

// File: rtl/pagerank_stream_tx.sv
// pagerank_stream_tx: gathers one partial pagerank vector per hardware thread,
// then streams the complete set downstream one vector per beat in thread order.
// Write side is open only while collecting; the stream side honours a hold.
module pagerank_stream_tx #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              wr_valid,
  input  logic [$clog2(NUM_HW_THREADS)-1:0] wr_thread_id,
  input  logic [64*NODES_IN_GRAPH-1:0]      wr_vector,
  output logic                              wr_ready,
  input  logic                              stream_hold,
  output logic [64*NODES_IN_GRAPH-1:0]      pagerank_serial_stream,
  output logic                              stream_start,
  output logic                              stream_valid,
  output logic                              stream_done,
  output logic [NUM_HW_THREADS-1:0]         thread_loaded,
  output logic                              dup_write_err
);

  localparam int          VEC_W     = 64 * NODES_IN_GRAPH;
  localparam int          ID_W      = $clog2(NUM_HW_THREADS);
  localparam int unsigned NT        = NUM_HW_THREADS;
  localparam logic [ID_W-1:0] LAST_BEAT = ID_W'(NUM_HW_THREADS - 1);

  typedef enum logic [1:0] {
    COLLECT,
    START,
    STREAM,
    DONE
  } state_t;

  state_t                   state;
  logic [ID_W-1:0]          beat_idx;
  logic [VEC_W-1:0]         slot [NUM_HW_THREADS];

  logic                     id_in_range;
  logic [NUM_HW_THREADS-1:0] wr_onehot;
  logic                     set_complete;
  logic                     accept;

  // Write side is open exactly while collecting.
  assign wr_ready = (state == COLLECT);
  assign accept   = wr_valid && wr_ready;

  // Decode the incoming thread id and detect the write that completes the set.
  always_comb begin
    id_in_range = ({{(32-ID_W){1'b0}}, wr_thread_id} < 32'(NUM_HW_THREADS));
    wr_onehot   = '0;
    if (id_in_range) begin
      wr_onehot[wr_thread_id] = 1'b1;
    end
    set_complete = id_in_range && (&(thread_loaded | wr_onehot));
  end

  // Collect/stream sequencer with registered stream outputs and slot buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= COLLECT;
      beat_idx               <= '0;
      thread_loaded          <= '0;
      dup_write_err          <= 1'b0;
      stream_start           <= 1'b0;
      stream_valid           <= 1'b0;
      stream_done            <= 1'b0;
      pagerank_serial_stream <= '0;
      for (int unsigned i = 0; i < NT; i++) begin
        slot[i] <= '0;
      end
    end else begin
      stream_start <= 1'b0;
      stream_done  <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (!id_in_range) begin
              dup_write_err <= 1'b1;
            end else begin
              slot[wr_thread_id] <= wr_vector;
              thread_loaded      <= thread_loaded | wr_onehot;
              if (thread_loaded[wr_thread_id]) begin
                dup_write_err <= 1'b1;
              end
              if (set_complete) begin
                state        <= START;
                stream_start <= 1'b1;
              end
            end
          end
        end
        START: begin
          state                  <= STREAM;
          beat_idx               <= '0;
          stream_valid           <= 1'b1;
          pagerank_serial_stream <= slot[0];
        end
        STREAM: begin
          if (!stream_hold) begin
            if (beat_idx == LAST_BEAT) begin
              // Flags are released as the stream completes so the done
              // cycle already shows an empty buffer.
              state                  <= DONE;
              beat_idx               <= '0;
              stream_valid           <= 1'b0;
              stream_done            <= 1'b1;
              thread_loaded          <= '0;
              pagerank_serial_stream <= '0;
            end else begin
              beat_idx               <= beat_idx + ID_W'(1);
              pagerank_serial_stream <= slot[beat_idx + ID_W'(1)];
            end
          end
        end
        DONE: begin
          state <= COLLECT;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_stream_tx.sv
// Scoreboard bench for pagerank_stream_tx: stimulus pushes expected beats and
// start cycles into queues; a negedge monitor pops and compares them.
module tb_pagerank_stream_tx;

  localparam int N     = 8;
  localparam int NODES = 32;
  localparam int VEC_W = 64 * NODES;
  localparam int ID_W  = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             wr_valid = 1'b0;
  logic [ID_W-1:0]  wr_thread_id = '0;
  logic [VEC_W-1:0] wr_vector = '0;
  logic             wr_ready;
  logic             stream_hold = 1'b0;
  logic [VEC_W-1:0] pagerank_serial_stream;
  logic             stream_start;
  logic             stream_valid;
  logic             stream_done;
  logic [N-1:0]     thread_loaded;
  logic             dup_write_err;

  pagerank_stream_tx #(.NUM_HW_THREADS(N), .NODES_IN_GRAPH(NODES)) dut (
    .clock(clock),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_thread_id(wr_thread_id),
    .wr_vector(wr_vector),
    .wr_ready(wr_ready),
    .stream_hold(stream_hold),
    .pagerank_serial_stream(pagerank_serial_stream),
    .stream_start(stream_start),
    .stream_valid(stream_valid),
    .stream_done(stream_done),
    .thread_loaded(thread_loaded),
    .dup_write_err(dup_write_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [VEC_W-1:0] m_slot [N];
  logic [N-1:0]     m_loaded = '0;
  logic             m_dup = 1'b0;
  logic [VEC_W-1:0] expq[$];
  int               exp_start_q[$];
  int               exp_starts = 0;
  int               exp_dones = 0;
  int               start_cnt = 0;
  int               done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    int w;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      w = 0;
      for (int j = NODES - 1; j >= 0; j--) begin
        if (got[j*64 +: 64] !== exp[j*64 +: 64]) w = j;
      end
      $display("FAIL %s: node %0d got %h expected %h (cycle %0d)", name, w,
               got[w*64 +: 64], exp[w*64 +: 64], cyc);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] dir_vec(input int t);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < NODES; i++) v[i*64 +: 64] = 64'(256 * t + i);
    return v;
  endfunction

  // Monitor: compares every presented beat / pulse against the scoreboard.
  int mon_start_cyc = 0;
  int mon_holds = 0;
  int mon_beats = 0;
  int mon_e;
  always @(negedge clock) begin
    if (!reset) begin
      if (stream_start) begin
        start_cnt++;
        if (exp_start_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          mon_e = exp_start_q.pop_front();
          chk("start_latency", 64'(cyc), 64'(mon_e));
        end
        chk("start_valid_low", stream_valid, 0);
        mon_start_cyc = cyc;
        mon_holds = 0;
        mon_beats = 0;
      end
      if (stream_valid) begin
        if (expq.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          chk_vec("beat_data", pagerank_serial_stream, expq[0]);
          if (!stream_hold) begin
            void'(expq.pop_front());
            mon_beats++;
          end else mon_holds++;
        end
      end else begin
        chk_vec("idle_zero", pagerank_serial_stream, '0);
      end
      if (stream_done) begin
        done_cnt++;
        chk("done_latency", 64'(cyc), 64'(mon_start_cyc + 1 + N + mon_holds));
        chk("done_beats", 64'(mon_beats), 64'(N));
      end
    end
  end

  task automatic do_write(input int id, input logic [VEC_W-1:0] v);
    int c;
    chk("wr_ready_collect", wr_ready, 1);
    wr_valid = 1'b1;
    wr_thread_id = ID_W'(id);
    wr_vector = v;
    c = cyc;
    @(posedge clock); #1;
    wr_valid = 1'b0;
    if (m_loaded[id]) m_dup = 1'b1;
    m_slot[id] = v;
    m_loaded[id] = 1'b1;
    if (&m_loaded) begin
      for (int j = 0; j < N; j++) expq.push_back(m_slot[j]);
      exp_start_q.push_back(c + 1);
      exp_starts++;
      exp_dones++;
    end
    chk("thread_loaded", 64'(thread_loaded), 64'(m_loaded));
    chk("dup_write_err", dup_write_err, m_dup);
  endtask

  task automatic do_abort();
    reset = 1'b1;
    wr_valid = 1'b0;
    stream_hold = 1'b0;
    @(posedge clock); #1;
    chk("rst_valid", stream_valid, 0);
    chk("rst_start", stream_start, 0);
    chk("rst_done", stream_done, 0);
    chk_vec("rst_data", pagerank_serial_stream, '0);
    chk("rst_loaded", 64'(thread_loaded), 0);
    chk("rst_dup", dup_write_err, 0);
    // a write presented while reset is still high must be dropped
    wr_valid = 1'b1;
    wr_thread_id = '0;
    wr_vector = rand_vec();
    @(posedge clock); #1;
    reset = 1'b0;
    wr_valid = 1'b0;
    expq.delete();
    exp_start_q.delete();
    exp_dones--;
    m_loaded = '0;
    m_dup = 1'b0;
    chk("write_during_reset", 64'(thread_loaded), 0);
    chk("wr_ready_after_reset", wr_ready, 1);
  endtask

  // hold_mode: 0 none, 1 three holds on beat 2, 2 random holds
  task automatic stream_phase(input int hold_mode, input bit garbage, input int abort_at);
    int b = 0;
    int held = 0;
    bit fin = 1'b0;
    bit h;
    for (int t = 0; t < 200 && !fin; t++) begin
      if (stream_done) fin = 1'b1;
      else begin
        chk("wr_ready_busy", wr_ready, 0);
        h = 1'b0;
        if (stream_valid) begin
          if (abort_at >= 0 && b == abort_at) begin
            do_abort();
            return;
          end
          if (hold_mode == 1) h = (b == 2 && held < 3);
          else if (hold_mode == 2) h = ($urandom_range(0, 3) == 0);
          if (h) held++;
          else b++;
        end else if (hold_mode == 2) begin
          h = ($urandom_range(0, 1) == 1);
        end
        stream_hold = h;
        if (garbage) begin
          wr_valid = 1'b1;
          wr_thread_id = ID_W'($urandom());
          wr_vector = rand_vec();
        end
        @(posedge clock); #1;
      end
    end
    wr_valid = 1'b0;
    stream_hold = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    @(posedge clock); #1;
    m_loaded = '0;
    chk("loaded_cleared", 64'(thread_loaded), 0);
    chk("wr_ready_after_done", wr_ready, 1);
  endtask

  task automatic run_iter(input bit directed, input bit dup3, input int hold_mode,
                          input bit garbage, input int abort_at);
    int order[N];
    int k;
    int tmp;
    for (int i = 0; i < N; i++) order[i] = directed ? (N - 1 - i) : i;
    if (!directed) begin
      for (int i = N - 1; i > 0; i--) begin
        k = $urandom_range(0, i);
        tmp = order[i];
        order[i] = order[k];
        order[k] = tmp;
      end
    end
    if (dup3) do_write(3, rand_vec());
    for (int i = 0; i < N; i++) begin
      do_write(order[i], directed ? dir_vec(order[i]) : rand_vec());
    end
    stream_phase(hold_mode, garbage, abort_at);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("init_valid", stream_valid, 0);
    chk("init_start", stream_start, 0);
    chk("init_done", stream_done, 0);
    chk_vec("init_data", pagerank_serial_stream, '0);
    chk("init_loaded", 64'(thread_loaded), 0);
    chk("init_dup", dup_write_err, 0);
    chk("init_wr_ready", wr_ready, 1);

    run_iter(1'b1, 1'b0, 0, 1'b0, -1);  // directed 7..0 pattern
    run_iter(1'b0, 1'b1, 1, 1'b1, -1);  // duplicate thread 3, hold beat 2, writes while busy
    run_iter(1'b0, 1'b0, 2, 1'b0, 4);   // reset during beat 4
    run_iter(1'b0, 1'b0, 2, 1'b1, -1);  // random holds
    run_iter(1'b0, 1'b0, 0, 1'b0, -1);  // back-to-back with previous

    repeat (3) @(posedge clock);
    #1;
    chk("start_count", 64'(start_cnt), 64'(exp_starts));
    chk("done_count", 64'(done_cnt), 64'(exp_dones));
    chk("queue_drained", 64'(expq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

endmodule
